// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags and
// overflow/underflow error pulses.
// Optional feature macro: SYNC_FIFO_FWFT_EN selects first-word-fall-through reads;
// when it is undefined, data_out is a register loaded on each accepted read.
module sync_fifo_flags #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned ADDR_SIZE     = 4,
  parameter int unsigned AFULL_THRESH  = 12,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     data_out,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;
  localparam int unsigned PW    = ADDR_SIZE + 1;

  localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q,  count_d;
  logic          overflow_q,  overflow_d;
  logic          underflow_q, underflow_d;

  logic          full_c;
  logic          empty_c;
  logic          wr_acc_c;
  logic          rd_acc_c;
  logic [ADDR_SIZE-1:0] rd_idx_c;

  // Status decode from registered pointers; wrap bit distinguishes full from empty
  always_comb begin
    full_c   = (wr_ptr_q[ADDR_SIZE] != rd_ptr_q[ADDR_SIZE]) &&
               (wr_ptr_q[ADDR_SIZE-1:0] == rd_ptr_q[ADDR_SIZE-1:0]);
    empty_c  = (wr_ptr_q == rd_ptr_q);
    wr_acc_c = rst && wr_en && !full_c;
    rd_acc_c = rst && rd_en && !empty_c;
    rd_idx_c = rd_ptr_q[ADDR_SIZE-1:0];
  end

  // Next-state for pointers, occupancy and error pulses
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = wr_en && full_c;
    underflow_d = rd_en && empty_c;
    if (wr_acc_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_acc_c) rd_ptr_d = rd_ptr_q + PW'(1);
    if (wr_acc_c && !rd_acc_c) count_d = count_q + PW'(1);
    else if (rd_acc_c && !wr_acc_c) count_d = count_q - PW'(1);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_acc_c) mem[wr_ptr_q[ADDR_SIZE-1:0]] <= data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word falls through; forced to zero while empty so reset reads back 0
  always_comb begin
    data_out = empty_c ? '0 : mem[rd_idx_c];
  end
`else
  logic [WIDTH-1:0] dout_q, dout_d;

  // Output register loads the head word on an accepted read, else holds
  always_comb begin
    dout_d = dout_q;
    if (rd_acc_c) dout_d = mem[rd_idx_c];
  end

  // Read data register
  always_ff @(posedge clk) begin
    if (!rst) dout_q <= '0;
    else      dout_q <= dout_d;
  end

  assign data_out = dout_q;
`endif

  // Flags and count derived from registered state
  always_comb begin
    fifo_full    = full_c;
    fifo_empty   = empty_c;
    count        = count_q;
    almost_full  = (count_q >= AFULL_LVL);
    almost_empty = (count_q <= AEMPTY_LVL);
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags using a queue-based reference model.
module tb_sync_fifo_flags;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AFULL  = 12;
  localparam int unsigned AEMPTY = 4;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;
  logic [7:0] data_out;
  logic       fifo_full, fifo_empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int errs   = 0;

  // Reference model state
  logic [7:0] m_q[$];
  logic [7:0] m_dout = 8'h00;
  logic       m_ovf  = 1'b0;
  logic       m_unf  = 1'b0;

  sync_fifo_flags #(
    .WIDTH(8), .ADDR_SIZE(4), .AFULL_THRESH(12), .AEMPTY_THRESH(4)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_dout();
`ifdef SYNC_FIFO_FWFT_EN
    return (m_q.size() != 0) ? m_q[0] : 8'h00;
`else
    return m_dout;
`endif
  endfunction

  // Drive one cycle, advance the model across the edge, settle 1 time unit
  task automatic step(input logic r, input logic w, input logic [7:0] d, input logic rd);
    bit full, empty;
    rst = r; wr_en = w; data_in = d; rd_en = rd;
    @(posedge clk);
    if (!r) begin
      m_q.delete();
      m_dout = 8'h00;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      full  = (m_q.size() == DEPTH);
      empty = (m_q.size() == 0);
      m_ovf = w && full;
      m_unf = rd && empty;
      if (rd && !empty) m_dout = m_q.pop_front();
      if (w && !full) m_q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 8'hEE, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (count !== 5'd0) begin errs++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (fifo_empty !== 1'b1) begin errs++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
    checks++; if (almost_empty !== 1'b1) begin errs++; $display("FAIL reset_aempty got=%b exp=1", almost_empty); end
    checks++; if (fifo_full !== 1'b0) begin errs++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
    checks++; if (almost_full !== 1'b0) begin errs++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errs++; $display("FAIL reset_err got=%b%b exp=00", overflow, underflow); end
    checks++; if (data_out !== 8'h00) begin errs++; $display("FAIL reset_dout got=%h exp=00", data_out); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1, 8'(i), 1'b0);
      checks++; if (count !== 5'(i)) begin errs++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i); end
      checks++; if (almost_full !== (i >= 12)) begin errs++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, almost_full, i >= 12); end
      checks++; if (fifo_full !== (i == 16)) begin errs++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, fifo_full, i == 16); end
    end
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    checks++; if (overflow !== 1'b1) begin errs++; $display("FAIL fill_ovf got=%b exp=1", overflow); end
    checks++; if (count !== 5'd16) begin errs++; $display("FAIL fill_ovf_count got=%0d exp=16", count); end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    checks++; if (overflow !== 1'b0) begin errs++; $display("FAIL fill_ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      checks++; if (data_out !== 8'(i)) begin errs++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, data_out, 8'(i)); end
      step(1'b1, 1'b0, 8'h00, 1'b1);
`else
      step(1'b1, 1'b0, 8'h00, 1'b1);
      checks++; if (data_out !== 8'(i)) begin errs++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, data_out, 8'(i)); end
`endif
      checks++; if (almost_empty !== ((16 - i) <= 4)) begin errs++; $display("FAIL drain_aempty i=%0d got=%b", i, almost_empty); end
    end
    checks++; if (fifo_empty !== 1'b1) begin errs++; $display("FAIL drain_empty got=%b exp=1", fifo_empty); end
    step(1'b1, 1'b0, 8'h00, 1'b1);
    checks++; if (underflow !== 1'b1) begin errs++; $display("FAIL drain_unf got=%b exp=1", underflow); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if (data_out !== 8'h10) begin errs++; $display("FAIL drain_hold got=%h exp=10", data_out); end
`endif
    step(1'b1, 1'b0, 8'h00, 1'b0);
    checks++; if (underflow !== 1'b0) begin errs++; $display("FAIL drain_unf_clear got=%b exp=0", underflow); end
  endtask

  task automatic test_back_to_back();
    while (m_q.size() < 8) step(1'b1, 1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 8'($urandom), 1'b1);
      checks++; if (count !== 5'd8) begin errs++; $display("FAIL b2b_count i=%0d got=%0d exp=8", i, count); end
      checks++; if (data_out !== exp_dout()) begin errs++; $display("FAIL b2b_data i=%0d got=%h exp=%h", i, data_out, exp_dout()); end
    end
    while (m_q.size() < DEPTH) step(1'b1, 1'b1, 8'($urandom), 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b1);
    checks++; if (count !== 5'd15) begin errs++; $display("FAIL b2b_full_count got=%0d exp=15", count); end
    checks++; if (overflow !== 1'b1) begin errs++; $display("FAIL b2b_full_ovf got=%b exp=1", overflow); end
    checks++; if (data_out !== exp_dout()) begin errs++; $display("FAIL b2b_full_data got=%h exp=%h", data_out, exp_dout()); end
    while (m_q.size() > 0) step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'h3C, 1'b1);
    checks++; if (count !== 5'd1) begin errs++; $display("FAIL b2b_empty_count got=%0d exp=1", count); end
    checks++; if (underflow !== 1'b1) begin errs++; $display("FAIL b2b_empty_unf got=%b exp=1", underflow); end
    step(1'b1, 1'b0, 8'h00, 1'b1);
    checks++; if (data_out !== exp_dout() || m_dout !== 8'h3C) begin errs++; $display("FAIL b2b_empty_data got=%h exp=%h", data_out, exp_dout()); end
  endtask

  task automatic test_mid_reset();
    while (m_q.size() < 9) step(1'b1, 1'b1, 8'($urandom), 1'b0);
    checks++; if (count !== 5'd9) begin errs++; $display("FAIL mrst_pre got=%0d exp=9", count); end
    step(1'b0, 1'b1, 8'hAB, 1'b0);
    checks++; if (count !== 5'd0) begin errs++; $display("FAIL mrst_count got=%0d exp=0", count); end
    checks++; if (fifo_empty !== 1'b1) begin errs++; $display("FAIL mrst_empty got=%b exp=1", fifo_empty); end
    step(1'b1, 1'b1, 8'h5C, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    checks++; if (data_out !== 8'h5C) begin errs++; $display("FAIL mrst_data got=%h exp=5c", data_out); end
    step(1'b1, 1'b0, 8'h00, 1'b1);
`else
    step(1'b1, 1'b0, 8'h00, 1'b1);
    checks++; if (data_out !== 8'h5C) begin errs++; $display("FAIL mrst_data got=%h exp=5c", data_out); end
`endif
    checks++; if (fifo_empty !== 1'b1) begin errs++; $display("FAIL mrst_after got=%b exp=1", fifo_empty); end
  endtask

`ifdef SYNC_FIFO_FWFT_EN
  task automatic test_fwft();
    while (m_q.size() > 0) step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'hA5, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    checks++; if (data_out !== 8'hA5) begin errs++; $display("FAIL fwft_data got=%h exp=a5", data_out); end
    step(1'b1, 1'b0, 8'h00, 1'b1);
    checks++; if (fifo_empty !== 1'b1) begin errs++; $display("FAIL fwft_empty got=%b exp=1", fifo_empty); end
  endtask
`endif

  task automatic test_random();
    logic r, w, rd;
    int unsigned sz;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 79) != 0);
      w  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
      rd = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
      step(r, w, 8'($urandom), rd);
      sz = m_q.size();
      checks++; if (count !== 5'(sz)) begin errs++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, count, sz); end
      checks++; if (fifo_full !== (sz == DEPTH)) begin errs++; $display("FAIL rnd_full i=%0d got=%b", i, fifo_full); end
      checks++; if (fifo_empty !== (sz == 0)) begin errs++; $display("FAIL rnd_empty i=%0d got=%b", i, fifo_empty); end
      checks++; if (almost_full !== (sz >= AFULL)) begin errs++; $display("FAIL rnd_afull i=%0d got=%b sz=%0d", i, almost_full, sz); end
      checks++; if (almost_empty !== (sz <= AEMPTY)) begin errs++; $display("FAIL rnd_aempty i=%0d got=%b sz=%0d", i, almost_empty, sz); end
      checks++; if (overflow !== m_ovf) begin errs++; $display("FAIL rnd_ovf i=%0d got=%b exp=%b", i, overflow, m_ovf); end
      checks++; if (underflow !== m_unf) begin errs++; $display("FAIL rnd_unf i=%0d got=%b exp=%b", i, underflow, m_unf); end
      checks++; if (data_out !== exp_dout()) begin errs++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, data_out, exp_dout()); end
    end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; data_in = 8'h00; rd_en = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_mid_reset();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end

endmodule
